mem_arbiter_2to1: RTL and testbench

- Sits directly downstream of the icache and dcache refill ports. Merges their two 16B memory request streams onto one main-memory port and routes in-order responses back to the issuing cache.
- Lets a processor-with-caches tile share a single memory port.
- Round-robin grant, a registered request output, and an in-order port-ID FIFO that tracks outstanding requests.
- Message opaque fields pass through untouched.

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/mem_arb_id_fifo.sv | 57 +++++
 rtl/mem_arbiter_2to1.sv | 119 +++++++++++
 tb/tb_mem_arbiter_2to1.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the 2:1 memory arbiter: port identifiers and the 16B memory
// request/response message layouts used on every port.
package mem_arb_pkg;

    typedef logic port_id_t;

    localparam port_id_t PORT_ICACHE = 1'b0;
    localparam port_id_t PORT_DCACHE = 1'b1;

    typedef struct packed {
        logic [2:0]   msg_type;
        logic [7:0]   opaque;
        logic [31:0]  addr;
        logic [3:0]   len;
        logic [127:0] data;
    } mem_req_16B_t;

    typedef struct packed {
        logic [2:0]   msg_type;
        logic [7:0]   opaque;
        logic [1:0]   test;
        logic [3:0]   len;
        logic [127:0] data;
    } mem_resp_16B_t;

endpackage

// File: rtl/mem_arb_id_fifo.sv
// In-order FIFO of port IDs for requests issued to memory; the head tells the
// arbiter which cache the next memory response belongs to.
module mem_arb_id_fifo
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  port_id_t                       push_id,
    input  logic                           pop,
    output port_id_t                       head,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           full,
    output logic                           empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    port_id_t        slots [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    // Full blocks a push even when a pop lands in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = slots[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Contents need no reset: the pointers alone define which slots are live.
    always_ff @(posedge clk) begin
        if (do_push) slots[wr_ptr] <= push_id;
    end

endmodule

// File: rtl/mem_arbiter_2to1.sv
// Round-robin merge of icache/dcache refill requests onto one memory port, with
// in-order routing of memory responses back to the issuing cache.
module mem_arbiter_2to1
    import mem_arb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic          clk,
    input  logic          reset,

    input  mem_req_16B_t  in0req_msg,
    input  logic          in0req_val,
    output logic          in0req_rdy,
    output mem_resp_16B_t in0resp_msg,
    output logic          in0resp_val,
    input  logic          in0resp_rdy,

    input  mem_req_16B_t  in1req_msg,
    input  logic          in1req_val,
    output logic          in1req_rdy,
    output mem_resp_16B_t in1resp_msg,
    output logic          in1resp_val,
    input  logic          in1resp_rdy,

    output mem_req_16B_t  memreq_msg,
    output logic          memreq_val,
    input  logic          memreq_rdy,
    input  mem_resp_16B_t memresp_msg,
    input  logic          memresp_val,
    output logic          memresp_rdy,

    output logic          err_unexpected_resp
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    logic [1:0]     req_val_vec;
    logic [1:0]     req_rdy_vec;
    logic [1:0]     resp_val_vec;
    logic [1:0]     resp_rdy_vec;
    logic           can_issue;
    logic           do_grant;
    port_id_t       grant_id;
    port_id_t       last_grant;
    port_id_t       head_id;
    logic           fifo_full;
    logic           fifo_empty;
    logic [CW-1:0]  fifo_count;
    logic           memresp_fire;

    assign req_val_vec  = {in1req_val, in0req_val};
    assign resp_rdy_vec = {in1resp_rdy, in0resp_rdy};

    // The output register can take a new request if it is empty or draining now.
    assign can_issue = (!memreq_val || memreq_rdy) && !fifo_full;
    assign do_grant  = can_issue && (in0req_val || in1req_val);

    always_comb begin
        grant_id = PORT_ICACHE;
        if (in0req_val && in1req_val) grant_id = ~last_grant;
        else if (in1req_val)          grant_id = PORT_DCACHE;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            assign req_rdy_vec[gi]  = do_grant && (grant_id == port_id_t'(gi));
            assign resp_val_vec[gi] = memresp_val && !fifo_empty && (head_id == port_id_t'(gi));
        end
    endgenerate

    assign in0req_rdy  = req_rdy_vec[0];
    assign in1req_rdy  = req_rdy_vec[1];
    assign in0resp_val = resp_val_vec[0];
    assign in1resp_val = resp_val_vec[1];

    // Both caches see the response payload; only the valid is steered.
    assign in0resp_msg  = memresp_msg;
    assign in1resp_msg  = memresp_msg;
    assign memresp_rdy  = !fifo_empty && resp_rdy_vec[head_id];
    assign memresp_fire = memresp_val && memresp_rdy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            memreq_val <= 1'b0;
            memreq_msg <= '0;
            last_grant <= PORT_DCACHE;
        end else if (do_grant) begin
            memreq_val <= 1'b1;
            memreq_msg <= (grant_id == PORT_DCACHE) ? in1req_msg : in0req_msg;
            last_grant <= grant_id;
        end else if (memreq_rdy) begin
            memreq_val <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_unexpected_resp <= 1'b0;
        end else if (memresp_val && (fifo_count == '0)) begin
            err_unexpected_resp <= 1'b1;
        end
    end

    mem_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (do_grant),
        .push_id (grant_id),
        .pop     (memresp_fire),
        .head    (head_id),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_mem_arbiter_2to1.sv
// Randomized scoreboard bench for mem_arbiter_2to1: a queue-based model of the
// arbitration and response-routing rules checks every cycle at the falling edge.
module tb_mem_arbiter_2to1;
    import mem_arb_pkg::*;

    localparam int MAXO = 4;

    logic          clk = 1'b0;
    logic          reset;
    mem_req_16B_t  req_msg  [2];
    logic [1:0]    req_val;
    logic [1:0]    req_rdy;
    mem_resp_16B_t resp_msg [2];
    logic [1:0]    resp_val;
    logic [1:0]    resp_rdy;
    mem_req_16B_t  memreq_msg;
    logic          memreq_val;
    logic          memreq_rdy;
    mem_resp_16B_t memresp_msg;
    logic          memresp_val;
    logic          memresp_rdy;
    logic          err;

    always #5 clk = ~clk;

    mem_arbiter_2to1 #(.MAX_OUTSTANDING(MAXO)) dut (
        .clk                 (clk),
        .reset               (reset),
        .in0req_msg          (req_msg[0]),
        .in0req_val          (req_val[0]),
        .in0req_rdy          (req_rdy[0]),
        .in0resp_msg         (resp_msg[0]),
        .in0resp_val         (resp_val[0]),
        .in0resp_rdy         (resp_rdy[0]),
        .in1req_msg          (req_msg[1]),
        .in1req_val          (req_val[1]),
        .in1req_rdy          (req_rdy[1]),
        .in1resp_msg         (resp_msg[1]),
        .in1resp_val         (resp_val[1]),
        .in1resp_rdy         (resp_rdy[1]),
        .memreq_msg          (memreq_msg),
        .memreq_val          (memreq_val),
        .memreq_rdy          (memreq_rdy),
        .memresp_msg         (memresp_msg),
        .memresp_val         (memresp_val),
        .memresp_rdy         (memresp_rdy),
        .err_unexpected_resp (err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Stimulus knobs
    bit          src_en = 1'b0;
    bit          fixed_addr = 1'b0;
    int unsigned src_pct = 0;
    int unsigned mrdy_pct = 100;
    int unsigned mresp_pct = 100;
    int unsigned rrdy_pct [2] = '{100, 100};
    int          seq [2] = '{0, 0};

    // Reference model state
    bit            mon_en = 1'b0;
    bit            out_busy = 1'b0;
    bit            last = 1'b1;
    bit            err_m = 1'b0;
    int            exp_ids [$];
    mem_req_16B_t  exp_req [$];
    mem_req_16B_t  port_q0 [$];
    mem_req_16B_t  port_q1 [$];
    mem_req_16B_t  mem_q [$];

    function automatic void chk1(string name, logic act, logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b, expected %0b at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void chkw(string name, logic [255:0] act, logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void fail(string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got event, expected none/other at %0t", name, $time);
    endfunction

    // Memory behaviour: echo type/opaque/len, data is the address replicated.
    function automatic mem_resp_16B_t mk_resp(mem_req_16B_t r);
        mem_resp_16B_t x;
        x.msg_type = r.msg_type;
        x.opaque   = r.opaque;
        x.test     = 2'b00;
        x.len      = r.len;
        x.data     = {4{r.addr}};
        return x;
    endfunction

    function automatic mem_req_16B_t new_msg(int p);
        mem_req_16B_t m;
        m.msg_type = 3'($urandom_range(1));
        m.opaque   = {p[0], seq[p][6:0]};
        m.addr     = fixed_addr ? (p == 1 ? 32'h200 : 32'h100) : {$urandom_range(32'hFFFF_FFFF)} & 32'hFFFF_FFF0;
        m.len      = 4'd0;
        m.data     = {$urandom, $urandom, $urandom, $urandom};
        seq[p]++;
        return m;
    endfunction

    function automatic void model_clear();
        out_busy = 1'b0;
        last     = 1'b1;
        err_m    = 1'b0;
        exp_ids.delete();
        exp_req.delete();
        port_q0.delete();
        port_q1.delete();
        mem_q.delete();
    endfunction

    // Monitor: predicts grants and routing from the rules and compares each cycle.
    always @(negedge clk) begin
        int           g;
        int           h;
        logic         can;
        mem_req_16B_t e;
        if (!reset && mon_en) begin
            chk1("err_unexpected_resp", err, err_m);
            can = (!out_busy || memreq_rdy) && (exp_ids.size() < MAXO);
            g = -1;
            if (can) begin
                if (req_val == 2'b11) g = last ? 0 : 1;
                else if (req_val[0])  g = 0;
                else if (req_val[1])  g = 1;
            end
            chk1("in0req_rdy", req_rdy[0], g == 0);
            chk1("in1req_rdy", req_rdy[1], g == 1);
            chk1("memreq_val", memreq_val, out_busy);

            if (memreq_val && memreq_rdy) begin
                if (exp_req.size() == 0) begin
                    fail("memreq_unexpected");
                end else begin
                    e = exp_req.pop_front();
                    chkw("memreq_msg", 256'(memreq_msg), 256'(e));
                end
                mem_q.push_back(memreq_msg);
            end

            if (exp_ids.size() == 0) begin
                chk1("memresp_rdy_idle", memresp_rdy, 1'b0);
                chk1("in0resp_val_idle", resp_val[0], 1'b0);
                chk1("in1resp_val_idle", resp_val[1], 1'b0);
                if (memresp_val) err_m = 1'b1;
            end else begin
                h = exp_ids[0];
                chk1("memresp_rdy", memresp_rdy, resp_rdy[h]);
                chk1("in0resp_val", resp_val[0], memresp_val && (h == 0));
                chk1("in1resp_val", resp_val[1], memresp_val && (h == 1));
                if (memresp_val && resp_rdy[h]) begin
                    e = (h == 1) ? port_q1.pop_front() : port_q0.pop_front();
                    chkw("resp_msg", 256'(resp_msg[h]), 256'(mk_resp(e)));
                    chkw("resp_msg_other", 256'(resp_msg[1-h]), 256'(memresp_msg));
                    void'(exp_ids.pop_front());
                    $display("resp -> port%0d opaque %02h addr %08h", h, e.opaque, e.addr);
                end
            end

            if (g >= 0) begin
                e = req_msg[g];
                exp_req.push_back(e);
                exp_ids.push_back(g);
                if (g == 1) port_q1.push_back(e);
                else        port_q0.push_back(e);
                last     = (g == 1);
                out_busy = 1'b1;
            end else if (memreq_rdy) begin
                out_busy = 1'b0;
            end
        end
    end

    task automatic run_src(input int p);
        logic taken;
        forever begin
            @(negedge clk);
            taken = req_val[p] && req_rdy[p];
            @(posedge clk);
            #1;
            if (src_en && !(req_val[p] && !taken)) begin
                if ($urandom_range(99) < src_pct) begin
                    req_msg[p] = new_msg(p);
                    req_val[p] = 1'b1;
                end else begin
                    req_val[p] = 1'b0;
                end
            end
        end
    endtask

    task automatic run_mem();
        logic consumed;
        forever begin
            @(negedge clk);
            consumed = memresp_val && memresp_rdy;
            @(posedge clk);
            #1;
            if (consumed) void'(mem_q.pop_front());
            if (!(memresp_val && !consumed)) begin
                if (mem_q.size() > 0 && $urandom_range(99) < mresp_pct) begin
                    memresp_msg = mk_resp(mem_q[0]);
                    memresp_val = 1'b1;
                end else begin
                    memresp_val = 1'b0;
                end
            end
        end
    endtask

    task automatic run_rdy();
        forever begin
            @(posedge clk);
            #1;
            memreq_rdy  = ($urandom_range(99) < mrdy_pct);
            resp_rdy[0] = ($urandom_range(99) < rrdy_pct[0]);
            resp_rdy[1] = ($urandom_range(99) < rrdy_pct[1]);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int           grants;
        int           found;
        logic [31:0]  prev_addr;
        mem_req_16B_t snap;

        reset       = 1'b1;
        req_val     = 2'b00;
        req_msg[0]  = '0;
        req_msg[1]  = '0;
        resp_rdy    = 2'b11;
        memreq_rdy  = 1'b0;
        memresp_val = 1'b0;
        memresp_msg = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk1("rst_memreq_val", memreq_val, 1'b0);
        chkw("rst_memreq_msg", 256'(memreq_msg), 256'(0));
        chk1("rst_err", err, 1'b0);
        chk1("rst_memresp_rdy", memresp_rdy, 1'b0);
        @(posedge clk); #1;
        reset  = 1'b0;
        mon_en = 1'b1;

        // Unexpected response right after reset
        @(posedge clk); #1;
        memresp_val = 1'b1;
        memresp_msg = mk_resp(new_msg(0));
        @(negedge clk);
        chk1("unexp_memresp_rdy", memresp_rdy, 1'b0);
        @(posedge clk); #1;
        memresp_val = 1'b0;
        repeat (4) @(negedge clk);
        chk1("err_sticky", err, 1'b1);
        @(posedge clk); #1;
        mon_en = 1'b0;
        reset  = 1'b1;
        model_clear();
        @(negedge clk);
        chk1("err_cleared_by_reset", err, 1'b0);
        @(posedge clk); #1;
        reset  = 1'b0;
        mon_en = 1'b1;

        fork
            run_src(0);
            run_src(1);
            run_mem();
            run_rdy();
        join_none

        // Single port-0 read
        @(posedge clk); #1;
        req_msg[0] = '{msg_type: 3'd0, opaque: 8'h05, addr: 32'h1000, len: 4'd0, data: 128'd0};
        req_val[0] = 1'b1;
        @(negedge clk);
        chk1("single_in0req_rdy", req_rdy[0], 1'b1);
        @(posedge clk); #1;
        req_val[0] = 1'b0;
        @(negedge clk);
        chk1("single_memreq_val", memreq_val, 1'b1);
        chkw("single_memreq_addr", 256'(memreq_msg.addr), 256'(32'h1000));
        chkw("single_memreq_opaque", 256'(memreq_msg.opaque), 256'(8'h05));
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            @(negedge clk);
            if (memresp_val) begin
                found = 1;
                chk1("single_in0resp_val", resp_val[0], 1'b1);
                chk1("single_in1resp_val", resp_val[1], 1'b0);
                chkw("single_resp_opaque", 256'(resp_msg[0].opaque), 256'(8'h05));
            end
        end
        if (found == 0) fail("single_read_timeout");

        // Both ports continuously valid: addresses must alternate
        @(posedge clk);
        fixed_addr = 1'b1;
        src_pct    = 100;
        src_en     = 1'b1;
        prev_addr  = 32'h0;
        repeat (30) begin
            @(negedge clk);
            if (memreq_val && memreq_rdy) begin
                if (prev_addr != 32'h0)
                    chkw("alt_order", 256'(memreq_msg.addr), 256'((prev_addr == 32'h100) ? 32'h200 : 32'h100));
                prev_addr = memreq_msg.addr;
            end
        end

        // Memory stalls the request port for 5 cycles
        @(posedge clk);
        mrdy_pct = 0;
        @(negedge clk);
        snap = memreq_msg;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk1("stall_memreq_val", memreq_val, 1'b1);
            chkw("stall_memreq_msg", 256'(memreq_msg), 256'(snap));
            chk1("stall_in0req_rdy", req_rdy[0], 1'b0);
            chk1("stall_in1req_rdy", req_rdy[1], 1'b0);
        end
        @(posedge clk);
        mrdy_pct = 100;

        // Memory withholds responses until the ID FIFO fills
        mresp_pct = 0;
        repeat (10) @(negedge clk);
        chk1("full_in0req_rdy", req_rdy[0], 1'b0);
        chk1("full_in1req_rdy", req_rdy[1], 1'b0);
        @(posedge clk);
        mresp_pct = 100;
        @(posedge clk);
        mresp_pct = 0;
        grants = 0;
        repeat (6) begin
            @(negedge clk);
            if ((req_val[0] && req_rdy[0]) || (req_val[1] && req_rdy[1])) grants++;
        end
        chkw("one_resp_one_grant", 256'(grants), 256'(1));

        // Port 1 refuses responses while random traffic flows
        @(posedge clk);
        fixed_addr  = 1'b0;
        src_pct     = 60;
        mrdy_pct    = 70;
        mresp_pct   = 100;
        rrdy_pct[1] = 0;
        repeat (40) @(negedge clk);
        @(posedge clk);
        rrdy_pct[1] = 100;

        // Fully random traffic
        src_pct     = 50;
        mrdy_pct    = 70;
        mresp_pct   = 60;
        rrdy_pct[0] = 80;
        rrdy_pct[1] = 80;
        repeat (2000) @(negedge clk);

        // Drain
        @(posedge clk);
        src_pct     = 0;
        mrdy_pct    = 100;
        mresp_pct   = 100;
        rrdy_pct[0] = 100;
        rrdy_pct[1] = 100;
        found = 0;
        for (int i = 0; i < 300 && found == 0; i++) begin
            @(negedge clk);
            if (exp_ids.size() == 0 && exp_req.size() == 0 && !memreq_val && req_val == 2'b00) found = 1;
        end
        if (found == 0) fail("drain_timeout");
        repeat (3) @(negedge clk);
        chk1("drained_memresp_rdy", memresp_rdy, 1'b0);
        chk1("drained_err", err, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
